groovy_cmd_sched: RTL and testbench
===================================

# groovy_cmd_sched

Single-owner scheduler for the Groovy command engines. Takes the level-held command flags from the HPS command decoder: switchres, audio, blit and LZ4 blit. Grants exactly one engine at a time, latches that command's parameters, and returns one-cycle acknowledge pulses that clear the decoder flags. Sits between the HPS extension decoder and the engine datapaths. Supervises each job with a watchdog.

## Interface
Parameters:
- TIMEOUT_W, 24: watchdog width; a job aborts after 2^TIMEOUT_W−1 cycles in BUSY without eng_done.
- MAX_AUDIO_RUN, 2: consecutive audio grants allowed while a video request (blit or LZ4) is pending.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_switchres, cmd_audio, cmd_blit, cmd_blit_lz4  in  1 each  level requests from the decoder
- lz4_size  in  32  compressed byte count of the LZ4 job
- lz4_AB  in  1  LZ4 buffer select
- audio_samples  in  16  sample count of the audio job
- vga_vblank  in  1  switchres may only be granted while high
- reset_switchres, reset_audio, reset_blit, reset_blit_lz4  out  1 each  acknowledge pulses
- eng_start  out  1  one-cycle job start
- eng_sel  out  2  0 switchres, 1 audio, 2 blit, 3 LZ4
- eng_len  out  32  job length
- eng_buf  out  1  latched lz4_AB
- eng_done  in  1  job complete
- eng_abort  out  1  one-cycle watchdog abort
- sched_busy  out  1  high in GRANT, BUSY and ABORT
- abort_cnt  out  8  saturating count of aborts

## Operation
- States: IDLE, GRANT, BUSY, ABORT.
- IDLE:
  - If any request is eligible, the arbiter picks a winner.
  - Next state is GRANT, with eng_sel, eng_len and eng_buf registered.
  - eng_len is lz4_size for LZ4, {16'd0, audio_samples} for audio, and 0 otherwise.
  - eng_buf is lz4_AB for LZ4; otherwise it holds its previous value.
- Eligibility and priority:
  - switchres is eligible only when vga_vblank=1. When blocked, it does not block lower requests.
  - Priority order is switchres > audio > blit_lz4 > blit.
  - Starvation guard: audio_run counts consecutive audio grants made while blit or LZ4 was pending. When audio_run==MAX_AUDIO_RUN and video is pending, video outranks audio.
  - audio_run clears on any non-audio grant, and whenever no video request is pending at grant time.
- GRANT lasts one cycle:
  - eng_start=1.
  - The matching reset_* pulses for one cycle.
  - Watchdog clears. Next state is BUSY.
- BUSY:
  - Watchdog increments each cycle.
  - eng_done=1 leads to IDLE.
  - If the watchdog reaches all-ones with no done, go to ABORT.
- ABORT lasts one cycle:
  - eng_abort=1.
  - abort_cnt increments, saturating at 255.
  - Next state is IDLE.
- eng_sel, eng_len and eng_buf stay stable from GRANT until the next GRANT.
- Reset values: all outputs 0, state IDLE, audio_run 0, watchdog 0.

## Timing
- Request sampled in IDLE at cycle N:
  - eng_start and reset_* are high at N+1.
  - BUSY begins at N+2.
- The decoder clears its flag at N+2. The scheduler is not in IDLE then, so there is no double grant.
- eng_done is honoured only in BUSY; it is ignored in IDLE, GRANT and ABORT. The minimum job is therefore start at N+1, done at N+2, back in IDLE at N+3.
- Back-to-back throughput: one grant per 3 cycles minimum.
- eng_done and watchdog terminal count in the same cycle: done wins, no abort.
- Requests arriving during GRANT, BUSY or ABORT are held by the decoder and arbitrated on the next IDLE cycle.
- Several requests in one IDLE cycle: exactly one grant; the rest wait.
- vga_vblank falling after switchres has been granted has no effect on the job.
- reset_n asserted mid-job: outputs clear immediately (asynchronously). No eng_abort is issued; engines share the same reset.

## Structure
- Package groovy_sched_pkg holds:
  - the state enum (IDLE, GRANT, BUSY, ABORT);
  - the eng_sel encodings ENG_SWITCHRES=0, ENG_AUDIO=1, ENG_BLIT=2, ENG_LZ4=3.
- Sub-module groovy_sched_arb:
  - combinational priority and eligibility logic, plus the registered audio_run counter;
  - outputs grant_valid and a 2-bit grant_sel.
- Top level holds the FSM, parameter latches, watchdog and abort counter.

## Test plan
- cmd_blit_lz4=1, lz4_size=32'h0001_2345, lz4_AB=1, held until reset_blit_lz4:
  - eng_start and reset_blit_lz4 high one cycle later;
  - eng_sel=3, eng_len=32'h12345, eng_buf=1;
  - eng_done 10 cycles later leads to IDLE.
- cmd_switchres, cmd_audio and cmd_blit all high with vga_vblank=0:
  - first grant is audio (eng_sel=1), then blit;
  - raise vblank: switchres is granted next.
- cmd_audio held continuously with cmd_blit held, MAX_AUDIO_RUN=2:
  - grant order is audio, audio, blit, audio, audio, blit.
- TIMEOUT_W=4, job started, eng_done never asserted:
  - eng_abort pulses exactly 15 cycles after BUSY entry;
  - abort_cnt=1; scheduler returns to IDLE.
- eng_done asserted in the same cycle as watchdog terminal count: no eng_abort, abort_cnt unchanged.
- reset_n pulsed low during BUSY: all outputs 0 at once, state IDLE; a pending cmd_blit is granted 1 cycle after release.

Source files
------------

// File: rtl/groovy_sched_pkg.sv
// Shared types and engine encodings for the Groovy command scheduler.
package groovy_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2,
    ABORT = 2'd3
  } sched_state_t;

  localparam logic [1:0] ENG_SWITCHRES = 2'd0;
  localparam logic [1:0] ENG_AUDIO     = 2'd1;
  localparam logic [1:0] ENG_BLIT      = 2'd2;
  localparam logic [1:0] ENG_LZ4       = 2'd3;

endpackage

// File: rtl/groovy_sched_arb.sv
// Request eligibility and priority for the command scheduler, including the
// audio run counter that keeps a busy audio stream from starving video work.
module groovy_sched_arb
  import groovy_sched_pkg::*;
#(
  parameter int MAX_AUDIO_RUN = 2
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       cmd_switchres,
  input  logic       cmd_audio,
  input  logic       cmd_blit,
  input  logic       cmd_blit_lz4,
  input  logic       vga_vblank,
  input  logic       grant_take,
  output logic       grant_valid,
  output logic [1:0] grant_sel
);

  localparam logic [7:0] MAX_RUN = 8'(MAX_AUDIO_RUN);

  logic [7:0] audio_run;
  logic       video_pending;
  logic       starve;

  // A blocked switchres falls through so lower requests are not held up.
  always_comb begin
    video_pending = cmd_blit | cmd_blit_lz4;
    starve        = video_pending && (audio_run >= MAX_RUN);
    grant_valid   = 1'b1;
    grant_sel     = ENG_BLIT;
    if (cmd_switchres && vga_vblank) begin
      grant_sel = ENG_SWITCHRES;
    end else if (cmd_audio && !starve) begin
      grant_sel = ENG_AUDIO;
    end else if (cmd_blit_lz4) begin
      grant_sel = ENG_LZ4;
    end else if (cmd_blit) begin
      grant_sel = ENG_BLIT;
    end else begin
      grant_valid = 1'b0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      audio_run <= '0;
    end else if (grant_take) begin
      if (grant_sel == ENG_AUDIO && video_pending) begin
        audio_run <= audio_run + 8'd1;
      end else begin
        audio_run <= '0;
      end
    end
  end

endmodule

// File: rtl/groovy_cmd_sched.sv
// Single-owner scheduler for the Groovy command engines: grants one job at a
// time, latches its parameters, acknowledges the decoder and watches for hangs.
module groovy_cmd_sched
  import groovy_sched_pkg::*;
#(
  parameter int TIMEOUT_W     = 24,
  parameter int MAX_AUDIO_RUN = 2
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cmd_switchres,
  input  logic        cmd_audio,
  input  logic        cmd_blit,
  input  logic        cmd_blit_lz4,
  input  logic [31:0] lz4_size,
  input  logic        lz4_AB,
  input  logic [15:0] audio_samples,
  input  logic        vga_vblank,
  output logic        reset_switchres,
  output logic        reset_audio,
  output logic        reset_blit,
  output logic        reset_blit_lz4,
  output logic        eng_start,
  output logic [1:0]  eng_sel,
  output logic [31:0] eng_len,
  output logic        eng_buf,
  input  logic        eng_done,
  output logic        eng_abort,
  output logic        sched_busy,
  output logic [7:0]  abort_cnt
);

  // Last watchdog value still in BUSY; the step to all-ones becomes the abort.
  localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

  sched_state_t         state;
  sched_state_t         state_next;
  logic [TIMEOUT_W-1:0] watchdog;
  logic                 grant_valid;
  logic [1:0]           grant_sel;
  logic                 grant_take;
  logic                 timeout_hit;

  assign grant_take  = (state == IDLE) && grant_valid;
  assign timeout_hit = (state == BUSY) && !eng_done && (watchdog == WD_LAST);

  groovy_sched_arb #(
    .MAX_AUDIO_RUN(MAX_AUDIO_RUN)
  ) u_arb (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .cmd_switchres(cmd_switchres),
    .cmd_audio    (cmd_audio),
    .cmd_blit     (cmd_blit),
    .cmd_blit_lz4 (cmd_blit_lz4),
    .vga_vblank   (vga_vblank),
    .grant_take   (grant_take),
    .grant_valid  (grant_valid),
    .grant_sel    (grant_sel)
  );

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // eng_done is only meaningful in BUSY, and it beats a simultaneous timeout.
  always_comb begin
    state_next      = state;
    eng_start       = 1'b0;
    eng_abort       = 1'b0;
    sched_busy      = 1'b1;
    reset_switchres = 1'b0;
    reset_audio     = 1'b0;
    reset_blit      = 1'b0;
    reset_blit_lz4  = 1'b0;
    case (state)
      IDLE: begin
        sched_busy = 1'b0;
        if (grant_valid) state_next = GRANT;
      end
      GRANT: begin
        eng_start       = 1'b1;
        reset_switchres = (eng_sel == ENG_SWITCHRES);
        reset_audio     = (eng_sel == ENG_AUDIO);
        reset_blit      = (eng_sel == ENG_BLIT);
        reset_blit_lz4  = (eng_sel == ENG_LZ4);
        state_next      = BUSY;
      end
      BUSY: begin
        if (eng_done) state_next = IDLE;
        else if (timeout_hit) state_next = ABORT;
      end
      ABORT: begin
        eng_abort  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      eng_sel <= ENG_SWITCHRES;
      eng_len <= '0;
      eng_buf <= 1'b0;
    end else if (grant_take) begin
      eng_sel <= grant_sel;
      case (grant_sel)
        ENG_LZ4:   eng_len <= lz4_size;
        ENG_AUDIO: eng_len <= {16'd0, audio_samples};
        default:   eng_len <= '0;
      endcase
      if (grant_sel == ENG_LZ4) eng_buf <= lz4_AB;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      watchdog <= '0;
    end else if (state == GRANT) begin
      watchdog <= '0;
    end else if (state == BUSY) begin
      watchdog <= watchdog + 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      abort_cnt <= '0;
    end else if (timeout_hit && abort_cnt != 8'hFF) begin
      abort_cnt <= abort_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_groovy_cmd_sched.sv
// Self-checking bench for groovy_cmd_sched: directed scenarios plus randomized
// job rounds checked against a job-level reference model.
module tb_groovy_cmd_sched;

  localparam int MAX_RUN = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_switchres = 1'b0;
  logic        cmd_audio = 1'b0;
  logic        cmd_blit = 1'b0;
  logic        cmd_blit_lz4 = 1'b0;
  logic [31:0] lz4_size = '0;
  logic        lz4_AB = 1'b0;
  logic [15:0] audio_samples = '0;
  logic        vga_vblank = 1'b0;
  logic        eng_done = 1'b0;
  logic        reset_switchres;
  logic        reset_audio;
  logic        reset_blit;
  logic        reset_blit_lz4;
  logic        eng_start;
  logic [1:0]  eng_sel;
  logic [31:0] eng_len;
  logic        eng_buf;
  logic        eng_abort;
  logic        sched_busy;
  logic [7:0]  abort_cnt;

  int n_checks = 0;
  int n_errors = 0;

  // Job-level model state
  int          m_run = 0;
  logic [1:0]  m_sel = 2'd0;
  logic [31:0] m_len = '0;
  logic        m_buf = 1'b0;
  int          m_aborts = 0;

  groovy_cmd_sched #(
    .TIMEOUT_W    (4),
    .MAX_AUDIO_RUN(MAX_RUN)
  ) dut (
    .clk_sys        (clk_sys),
    .reset_n        (reset_n),
    .cmd_switchres  (cmd_switchres),
    .cmd_audio      (cmd_audio),
    .cmd_blit       (cmd_blit),
    .cmd_blit_lz4   (cmd_blit_lz4),
    .lz4_size       (lz4_size),
    .lz4_AB         (lz4_AB),
    .audio_samples  (audio_samples),
    .vga_vblank     (vga_vblank),
    .reset_switchres(reset_switchres),
    .reset_audio    (reset_audio),
    .reset_blit     (reset_blit),
    .reset_blit_lz4 (reset_blit_lz4),
    .eng_start      (eng_start),
    .eng_sel        (eng_sel),
    .eng_len        (eng_len),
    .eng_buf        (eng_buf),
    .eng_done       (eng_done),
    .eng_abort      (eng_abort),
    .sched_busy     (sched_busy),
    .abort_cnt      (abort_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  function automatic logic [3:0] ack_vec(input logic [1:0] sel);
    logic [3:0] v;
    v = 4'b1000;
    return v >> sel;
  endfunction

  // One scheduling opportunity from an IDLE cycle. lat = BUSY cycle on which
  // eng_done rises (1..15), or 0 to let the watchdog expire.
  task automatic do_round(input int lat, input bit jitter, output logic [1:0] got);
    logic       video;
    logic       any;
    logic [1:0] pick;
    logic       vb_save;
    video = cmd_blit | cmd_blit_lz4;
    any   = (cmd_switchres && vga_vblank) || cmd_audio || video;
    got   = 2'd0;
    if (jitter) eng_done = 1'($urandom_range(0, 1));
    if (!any) begin
      step();
      eng_done = 1'b0;
      check("idle_quiet", {62'd0, sched_busy, eng_start}, 64'd0);
      return;
    end
    if (cmd_switchres && vga_vblank) pick = 2'd0;
    else if (cmd_audio && !(video && m_run == MAX_RUN)) pick = 2'd1;
    else if (cmd_blit_lz4) pick = 2'd3;
    else pick = 2'd2;
    m_run = (pick == 2'd1 && video) ? m_run + 1 : 0;
    m_sel = pick;
    m_len = (pick == 2'd3) ? lz4_size : (pick == 2'd1) ? {16'd0, audio_samples} : 32'd0;
    if (pick == 2'd3) m_buf = lz4_AB;

    step();
    eng_done = 1'b0;
    check("grant_start", {63'd0, eng_start}, 64'd1);
    check("grant_sel", {62'd0, eng_sel}, {62'd0, m_sel});
    check("grant_len", {32'd0, eng_len}, {32'd0, m_len});
    check("grant_buf", {63'd0, eng_buf}, {63'd0, m_buf});
    check("grant_ack", {60'd0, reset_switchres, reset_audio, reset_blit, reset_blit_lz4},
          {60'd0, ack_vec(m_sel)});
    got = eng_sel;
    case (pick)
      2'd0: cmd_switchres = 1'b0;
      2'd1: cmd_audio = 1'b0;
      2'd2: cmd_blit = 1'b0;
      default: cmd_blit_lz4 = 1'b0;
    endcase
    vb_save = vga_vblank;
    if (jitter) begin
      vga_vblank    = 1'($urandom_range(0, 1));
      eng_done      = 1'($urandom_range(0, 1));
      lz4_size      = $urandom;
      lz4_AB        = 1'($urandom_range(0, 1));
      audio_samples = 16'($urandom);
    end

    step();
    eng_done   = 1'b0;
    vga_vblank = vb_save;
    check("busy_enter", {57'd0, sched_busy, eng_start, reset_switchres, reset_audio,
          reset_blit, reset_blit_lz4, eng_abort}, {57'd0, 7'b1000000});

    if (lat == 0) begin
      for (int i = 0; i < 14; i++) begin
        step();
        check("wd_running", {62'd0, sched_busy, eng_abort}, 64'd2);
      end
      step();
      check("abort_pulse", {62'd0, sched_busy, eng_abort}, 64'd3);
      if (m_aborts < 255) m_aborts++;
      step();
      check("abort_exit", {62'd0, sched_busy, eng_abort}, 64'd0);
    end else begin
      for (int i = 1; i < lat; i++) begin
        step();
        check("busy_hold", {62'd0, sched_busy, eng_abort}, 64'd2);
      end
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
      check("done_exit", {62'd0, sched_busy, eng_abort}, 64'd0);
    end
    check("abort_cnt", {56'd0, abort_cnt}, 64'(m_aborts));
    check("params_stable", {29'd0, eng_sel, eng_buf, eng_len}, {29'd0, m_sel, m_buf, m_len});
  endtask

  initial begin
    logic [1:0] s;
    logic [1:0] order [6];
    order = '{2'd1, 2'd1, 2'd2, 2'd1, 2'd1, 2'd2};

    #2;
    check("reset_outputs", {13'd0, reset_switchres, reset_audio, reset_blit, reset_blit_lz4,
          eng_start, eng_sel, eng_len, eng_buf, eng_abort, sched_busy, abort_cnt}, 64'd0);
    #10 reset_n = 1'b1;
    step();
    check("idle_after_reset", {63'd0, sched_busy}, 64'd0);

    // LZ4 job with parameters latched and a 10-cycle job
    cmd_blit_lz4 = 1'b1;
    lz4_size     = 32'h0001_2345;
    lz4_AB       = 1'b1;
    do_round(10, 1'b0, s);
    check("lz4_sel", {62'd0, s}, 64'd3);
    check("lz4_len", {32'd0, eng_len}, 64'h12345);
    check("lz4_buf", {63'd0, eng_buf}, 64'd1);

    // switchres blocked outside vblank
    cmd_switchres = 1'b1;
    cmd_audio     = 1'b1;
    cmd_blit      = 1'b1;
    vga_vblank    = 1'b0;
    do_round(3, 1'b0, s);
    check("vb_first_audio", {62'd0, s}, 64'd1);
    do_round(2, 1'b0, s);
    check("vb_then_blit", {62'd0, s}, 64'd2);
    vga_vblank = 1'b1;
    do_round(2, 1'b0, s);
    check("vb_switchres", {62'd0, s}, 64'd0);
    vga_vblank = 1'b0;

    // audio starvation guard
    cmd_audio = 1'b1;
    cmd_blit  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_round(1, 1'b0, s);
      check("starve_order", {62'd0, s}, {62'd0, order[i]});
      cmd_audio = 1'b1;
      cmd_blit  = 1'b1;
    end
    cmd_audio = 1'b0;
    cmd_blit  = 1'b0;

    // watchdog abort, then done on the terminal cycle
    cmd_blit = 1'b1;
    do_round(0, 1'b0, s);
    check("abort_cnt_one", {56'd0, abort_cnt}, 64'd1);
    cmd_blit = 1'b1;
    do_round(15, 1'b0, s);
    check("terminal_done", {56'd0, abort_cnt}, 64'd1);

    // asynchronous reset mid-job
    cmd_audio     = 1'b1;
    audio_samples = 16'h0055;
    step();
    step();
    cmd_audio = 1'b0;
    check("midjob_busy", {63'd0, sched_busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check("midjob_reset", {13'd0, reset_switchres, reset_audio, reset_blit, reset_blit_lz4,
          eng_start, eng_sel, eng_len, eng_buf, eng_abort, sched_busy, abort_cnt}, 64'd0);
    m_run = 0; m_sel = 2'd0; m_len = '0; m_buf = 1'b0; m_aborts = 0;
    cmd_blit = 1'b1;
    #1 reset_n = 1'b1;
    do_round(1, 1'b0, s);
    check("post_reset_blit", {62'd0, s}, 64'd2);

    // randomized rounds
    for (int r = 0; r < 80; r++) begin
      if ($urandom_range(0, 2) == 0) cmd_switchres = 1'b1;
      if ($urandom_range(0, 2) == 0) cmd_audio = 1'b1;
      if ($urandom_range(0, 2) == 0) cmd_blit = 1'b1;
      if ($urandom_range(0, 2) == 0) cmd_blit_lz4 = 1'b1;
      vga_vblank    = 1'($urandom_range(0, 1));
      lz4_size      = $urandom;
      lz4_AB        = 1'($urandom_range(0, 1));
      audio_samples = 16'($urandom);
      do_round(($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15)), 1'b1, s);
    end

    // abort counter saturation
    cmd_switchres = 1'b0;
    cmd_audio     = 1'b0;
    cmd_blit_lz4  = 1'b0;
    for (int i = 0; i < 260; i++) begin
      cmd_blit = 1'b1;
      do_round(0, 1'b0, s);
    end
    check("abort_saturate", {56'd0, abort_cnt}, 64'd255);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
